// File: rtl/string_accel_avalon.sv
// Avalon-MM string accelerator: two string buffers, a read-only result buffer and
// a byte-serial engine running STRLEN/STRCMP/STRCPY/STRCAT/TOUPPER one byte per clock.
module string_accel_avalon #(
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);
    localparam int unsigned NB   = 4 * MAX_WORDS;
    localparam int unsigned PW   = $clog2(NB) + 1;
    localparam int unsigned BI_W = $clog2(NB);
    localparam int unsigned WI_W = $clog2(MAX_WORDS);

    localparam logic [2:0] OP_STRLEN  = 3'd0;
    localparam logic [2:0] OP_STRCMP  = 3'd1;
    localparam logic [2:0] OP_STRCPY  = 3'd2;
    localparam logic [2:0] OP_STRCAT  = 3'd3;
    localparam logic [2:0] OP_TOUPPER = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_RUN_A, S_RUN_B, S_DONE} state_t;

    state_t state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        trunc_q, trunc_d;
    logic        irq_q, irq_d;
    logic [31:0] scalar_q, scalar_d;
    logic [31:0] readdata_q;
    logic [PW-1:0] i_q, i_d, j_q, j_d, o_q, o_d;
    logic [MAX_WORDS-1:0][3:0][7:0] a_q, a_d, b_q, b_d, res_q, res_d;

    logic        wr_c, rd_c, busy_c;
    logic        in_a_c, in_b_c, in_r_c;
    logic [31:0] addr_c, rdata_c;
    logic [WI_W-1:0] a_w_c, b_w_c, r_w_c;
    logic [7:0]  a_byte_c, b_byte_i_c, b_byte_j_c, upper_c;
    logic [8:0]  diff_c;
    logic        last_i_c, last_o_c;
    logic        unused_wdata;

    assign wr_c   = chipselect & write;
    assign rd_c   = chipselect & read & ~write;
    assign busy_c = (state_q == S_RUN_A) || (state_q == S_RUN_B);
    assign unused_wdata = ^{writedata[31:10], writedata[8:5]};

    // Address decode into the three word-addressed buffers
    assign addr_c = 32'(address);
    assign in_a_c = (addr_c >= 32'd2) && (addr_c < 32'(MAX_WORDS + 2));
    assign in_b_c = (addr_c >= 32'(MAX_WORDS + 2)) && (addr_c < 32'(2 * MAX_WORDS + 2));
    assign in_r_c = (addr_c >= 32'(2 * MAX_WORDS + 2)) && (addr_c < 32'(3 * MAX_WORDS + 2));
    assign a_w_c  = WI_W'(addr_c - 32'd2);
    assign b_w_c  = WI_W'(addr_c - 32'(MAX_WORDS + 2));
    assign r_w_c  = WI_W'(addr_c - 32'(2 * MAX_WORDS + 2));

    assign a_byte_c   = a_q[i_q[BI_W-1:2]][i_q[1:0]];
    assign b_byte_i_c = b_q[i_q[BI_W-1:2]][i_q[1:0]];
    assign b_byte_j_c = b_q[j_q[BI_W-1:2]][j_q[1:0]];
    assign upper_c    = ((a_byte_c >= 8'h61) && (a_byte_c <= 8'h7A)) ? a_byte_c - 8'h20 : a_byte_c;
    assign diff_c     = {1'b0, a_byte_c} - {1'b0, b_byte_i_c};
    assign last_i_c   = (i_q == PW'(NB - 1));
    assign last_o_c   = (o_q == PW'(NB - 1));

    always_comb begin
        rdata_c = '0;
        if (addr_c == 32'd0)
            rdata_c = {20'd0, trunc_q, error_q, done_q, busy_c, 3'd0, irq_en_q, op_q, 1'b0};
        else if (addr_c == 32'd1)
            rdata_c = scalar_q;
        else if (in_a_c)
            rdata_c = a_q[a_w_c];
        else if (in_b_c)
            rdata_c = b_q[b_w_c];
        else if (in_r_c)
            rdata_c = res_q[r_w_c];
    end

    // Next-state: bus side first, engine second so a finishing op wins over a same-cycle W1C
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        error_d  = error_q;
        trunc_d  = trunc_q;
        scalar_d = scalar_q;
        i_d      = i_q;
        j_d      = j_q;
        o_d      = o_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;

        if (wr_c) begin
            if (addr_c == 32'd0) begin
                irq_en_d = writedata[4];
                if (writedata[9])
                    done_d = 1'b0;
                if (!busy_c)
                    op_d = writedata[3:1];
                if ((state_q == S_IDLE) && writedata[0]) begin
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    trunc_d  = 1'b0;
                    scalar_d = '0;
                    res_d    = '0;
                    i_d      = '0;
                    j_d      = '0;
                    o_d      = '0;
                    if (writedata[3:1] > OP_TOUPPER) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_RUN_A;
                    end
                end
            end else if (in_a_c && !busy_c) begin
                a_d[a_w_c] = writedata;
            end else if (in_b_c && !busy_c) begin
                b_d[b_w_c] = writedata;
            end
        end

        case (state_q)
            S_RUN_A: begin
                case (op_q)
                    OP_STRLEN, OP_STRCPY, OP_TOUPPER: begin
                        if (op_q != OP_STRLEN)
                            res_d[i_q[BI_W-1:2]][i_q[1:0]] = (op_q == OP_TOUPPER) ? upper_c : a_byte_c;
                        if ((a_byte_c == 8'h00) || last_i_c) begin
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                            scalar_d = (a_byte_c == 8'h00) ? 32'(i_q) : 32'(NB);
                        end else begin
                            i_d = i_q + PW'(1);
                        end
                    end
                    OP_STRCMP: begin
                        if ((diff_c != 9'd0) || (a_byte_c == 8'h00) || last_i_c) begin
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                            scalar_d = {{24{diff_c[8]}}, diff_c[7:0]};
                        end else begin
                            i_d = i_q + PW'(1);
                        end
                    end
                    OP_STRCAT: begin
                        if (a_byte_c == 8'h00) begin
                            state_d = S_RUN_B;
                            j_d     = '0;
                            o_d     = i_q;
                        end else begin
                            res_d[i_q[BI_W-1:2]][i_q[1:0]] = a_byte_c;
                            if (last_i_c) begin
                                state_d  = S_DONE;
                                done_d   = 1'b1;
                                trunc_d  = 1'b1;
                                scalar_d = 32'(NB);
                            end else begin
                                i_d = i_q + PW'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                endcase
            end
            S_RUN_B: begin
                res_d[o_q[BI_W-1:2]][o_q[1:0]] = b_byte_j_c;
                if (b_byte_j_c == 8'h00) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    scalar_d = 32'(o_q);
                end else if (last_o_c) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    trunc_d  = 1'b1;
                    scalar_d = 32'(NB);
                end else begin
                    j_d = j_q + PW'(1);
                    o_d = o_q + PW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            trunc_q    <= 1'b0;
            irq_q      <= 1'b0;
            scalar_q   <= '0;
            readdata_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            o_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            error_q    <= error_d;
            trunc_q    <= trunc_d;
            irq_q      <= irq_d;
            scalar_q   <= scalar_d;
            readdata_q <= rd_c ? rdata_c : readdata_q;
            i_q        <= i_d;
            j_q        <= j_d;
            o_q        <= o_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
